// File: rtl/one_hot_mux_pipe.sv
// Registered one-hot slice mux behind a valid/ready handshake with a 2-entry skid buffer.
// Each beat carries a one-hot violation flag. Violations are counted when the beat is accepted.
module one_hot_mux_pipe #(
   parameter int WIDTH         = 32,
   parameter int CNT           = 5,
   parameter int ONE_HOT_CHECK = 0,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [WIDTH*CNT-1:0] din,
   input  logic [CNT-1:0]       sel,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [WIDTH-1:0]     dout,
   output logic                 out_err,
   input  logic                 err_clr,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   function automatic logic [WIDTH-1:0] mux_or(input logic [WIDTH*CNT-1:0] d,
                                               input logic [CNT-1:0] s);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < CNT; i++)
         if (s[i]) r = r | d[i*WIDTH +: WIDTH];
      return r;
   endfunction

   function automatic logic one_hot_viol(input logic [CNT-1:0] s);
      int n;
      n = $countones(s);
      return ((ONE_HOT_CHECK >= 1) && (n > 1)) || ((ONE_HOT_CHECK == 2) && (n == 0));
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic [WIDTH-1:0] mux_p0;
   logic             viol_p0;
   logic [WIDTH-1:0] skid_dat_p1;
   logic             skid_err_p1;
   logic             skid_vld_p1;
   logic             in_xfer, out_xfer;
   logic             load_main, load_skid, skid_to_main, viol_acc;

   // Stage p0: combinational select and check on the incoming beat
   always_comb begin
      mux_p0  = mux_or(din, sel);
      viol_p0 = one_hot_viol(sel);
   end

   assign in_rdy       = !skid_vld_p1;
   assign in_xfer      = in_vld && in_rdy;
   assign out_xfer     = out_vld && out_rdy;
   assign skid_to_main = skid_vld_p1 && out_xfer;
   assign load_main    = in_xfer && (!out_vld || out_xfer);
   assign load_skid    = in_xfer && out_vld && !out_xfer;
   assign viol_acc     = in_xfer && viol_p0;

   // Stage p1: main output register and skid occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld     <= 1'b0;
         dout        <= '0;
         out_err     <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else begin
         if (skid_to_main) begin
            dout    <= skid_dat_p1;
            out_err <= skid_err_p1;
         end else if (load_main) begin
            dout    <= mux_p0;
            out_err <= viol_p0;
            out_vld <= 1'b1;
         end else if (out_xfer) begin
            out_vld <= 1'b0;
         end
         if (load_skid)
            skid_vld_p1 <= 1'b1;
         else if (skid_to_main)
            skid_vld_p1 <= 1'b0;
      end
   end

   // Skid payload is qualified by skid_vld_p1, so it needs no reset
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_dat_p1 <= mux_p0;
         skid_err_p1 <= viol_p0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else begin
         err_sticky <= viol_acc || (err_sticky && !err_clr);
         if (err_clr)
            err_cnt <= ERR_CNT_W'(viol_acc);
         else if (viol_acc)
            err_cnt <= sat_inc(err_cnt);
      end
   end

endmodule

// File: tb/tb_one_hot_mux_pipe.sv
// Bench for one_hot_mux_pipe: directed vector table, hand sequences for backpressure,
// saturation and async reset, then random traffic against a queue-based reference.
module tb_one_hot_mux_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_vld = 1'b0, out_rdy = 1'b0, err_clr = 1'b0;
   logic [31:0] din = '0;
   logic [3:0]  sel = '0;
   logic        in_rdy, out_vld, out_err, err_sticky;
   logic [7:0]  dout;
   logic [1:0]  err_cnt;
   logic        in_rdy1, out_vld1, out_err1, err_sticky1;
   logic [7:0]  dout1;
   logic [1:0]  err_cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   one_hot_mux_pipe #(.WIDTH(8), .CNT(4), .ONE_HOT_CHECK(2), .ERR_CNT_W(2)) u0 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .din(din), .sel(sel),
      .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout), .out_err(out_err),
      .err_clr(err_clr), .err_sticky(err_sticky), .err_cnt(err_cnt));

   one_hot_mux_pipe #(.WIDTH(8), .CNT(4), .ONE_HOT_CHECK(0), .ERR_CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy1), .din(din), .sel(sel),
      .out_vld(out_vld1), .out_rdy(out_rdy), .dout(dout1), .out_err(out_err1),
      .err_clr(err_clr), .err_sticky(err_sticky1), .err_cnt(err_cnt1));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } beat_t;

   beat_t      mq[$];
   logic [7:0] m_dout = '0;
   int         m_cnt = 0;
   bit         m_sticky = 1'b0;

   typedef struct {
      logic [31:0] din;
      logic [3:0]  sel;
      logic [7:0]  exp_dout;
      logic        exp_err;
      int          exp_cnt;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_mux(input logic [31:0] d, input logic [3:0] s);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 4; i++)
         if (s[i]) r = r | d[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_dout   = '0;
      m_cnt    = 0;
      m_sticky = 1'b0;
   endtask

   task automatic check_all();
      chk("in_rdy", in_rdy, mq.size() < 2);
      chk("out_vld", out_vld, mq.size() > 0);
      chk("dout", dout, m_dout);
      if (mq.size() > 0) chk("out_err", out_err, mq[0].e);
      chk("err_sticky", err_sticky, m_sticky);
      chk("err_cnt", err_cnt, m_cnt);
      chk("u1_in_rdy", in_rdy1, mq.size() < 2);
      chk("u1_out_vld", out_vld1, mq.size() > 0);
      chk("u1_dout", dout1, m_dout);
      chk("u1_err", {out_err1, err_sticky1, err_cnt1}, 0);
   endtask

   task automatic tick();
      beat_t b;
      bit    acc, tk, v;
      acc = in_vld && (mq.size() < 2);
      tk  = out_rdy && (mq.size() > 0);
      b.d = ref_mux(din, sel);
      b.e = ($countones(sel) != 1);
      v   = acc && b.e;
      if (err_clr) begin
         m_cnt    = v ? 1 : 0;
         m_sticky = v;
      end else if (v) begin
         m_sticky = 1'b1;
         if (m_cnt < 3) m_cnt++;
      end
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back(b);
      if (mq.size() > 0) m_dout = mq[0].d;
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      vt[0] = '{32'h44332211, 4'b0100, 8'h33, 1'b0, 0};
      vt[1] = '{32'h44332211, 4'b0011, 8'h33, 1'b1, 1};
      vt[2] = '{32'h44332211, 4'b0000, 8'h00, 1'b1, 2};
      vt[3] = '{32'h44332211, 4'b1111, 8'h77, 1'b1, 3};
      vt[4] = '{32'ha5c30f81, 4'b1000, 8'ha5, 1'b0, 3};
      vt[5] = '{32'ha5c30f81, 4'b0001, 8'h81, 1'b0, 3};
      vt[6] = '{32'ha5c30f81, 4'b0110, 8'hcf, 1'b1, 3};

      // reset state
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single beats from the vector table
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      for (int i = 0; i < 7; i++) begin
         din = vt[i].din; sel = vt[i].sel; in_vld = 1'b1; out_rdy = 1'b1;
         tick();
         in_vld = 1'b0;
         chk("tbl_vld", out_vld, 1);
         chk("tbl_dout", dout, vt[i].exp_dout);
         chk("tbl_err", out_err, vt[i].exp_err);
         chk("tbl_cnt", err_cnt, vt[i].exp_cnt);
         chk("tbl_u1_dout", dout1, vt[i].exp_dout);
         tick();
      end

      // backpressure: third beat waits for the skid to drain
      out_rdy = 1'b0; din = 32'h44332211; sel = 4'b0001; in_vld = 1'b1;
      tick();
      chk("bp_d1", dout, 8'h11);
      sel = 4'b0010;
      tick();
      chk("bp_full", in_rdy, 0);
      sel = 4'b0100;
      tick();
      chk("bp_hold", dout, 8'h11);
      out_rdy = 1'b1;
      tick();
      chk("bp_d2", dout, 8'h22);
      chk("bp_rdy", in_rdy, 1);
      tick();
      chk("bp_d3", dout, 8'h33);
      in_vld = 1'b0;
      tick();
      chk("bp_empty", out_vld, 0);
      chk("bp_keep", dout, 8'h33);

      // saturation and clear coinciding with a violation
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      sel = 4'b0011; in_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sat_cnt", err_cnt, (i < 3) ? i + 1 : 3);
         chk("sat_sticky", err_sticky, 1);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0; in_vld = 1'b0;
      chk("clr_viol_cnt", err_cnt, 1);
      chk("clr_viol_sticky", err_sticky, 1);
      tick();

      // async reset while both stages hold beats
      out_rdy = 1'b0; in_vld = 1'b1; sel = 4'b0011;
      tick();
      tick();
      in_vld = 1'b0;
      chk("two_state", in_rdy, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_vld", out_vld, 0);
      chk("arst_dout", dout, 0);
      chk("arst_rdy", in_rdy, 1);
      chk("arst_err", {err_sticky, err_cnt}, 0);
      model_reset();
      #1 rst = 1'b0;
      tick();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 9) < 7);
         din     = $urandom;
         sel     = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
         err_clr = ($urandom_range(0, 19) == 0);
         tick();
      end
      in_vld = 1'b0; err_clr = 1'b0; out_rdy = 1'b1;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
